// File: rtl/serial_add_host.sv
// serial_add_host: parallel-side driver for a bit-serial adder.
// Streams operands LSB-first and collects the sum into a parallel word.
module serial_add_host #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             sa_a,
   output logic             sa_b,
   output logic             sa_cin,
   output logic             sa_first,
   input  logic             sa_s,
   input  logic             sa_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] sum_q;
   logic             cin_q;
   logic             cout_q;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next state, handshakes and serial-side drive
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      sa_a       = 1'b0;
      sa_b       = 1'b0;
      sa_cin     = 1'b0;
      sa_first   = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            sa_a     = a_sr[0];
            sa_b     = b_sr[0];
            sa_first = (cnt == '0);
            sa_cin   = (cnt == '0) & cin_q;
            if (cnt == LAST) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // operand/sum shifters, bit counter and held result
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr   <= '0;
         b_sr   <= '0;
         s_sr   <= '0;
         sum_q  <= '0;
         cin_q  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sr  <= op_a;
         b_sr  <= op_b;
         cin_q <= op_cin;
         s_sr  <= '0;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         s_sr <= {sa_s, s_sr[WIDTH-1:1]};
         if (last) begin
            cnt    <= '0;
            sum_q  <= {sa_s, s_sr[WIDTH-1:1]};
            cout_q <= sa_cout;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_host.sv
// tb_serial_add_host: drives serial_add_host against a behavioural
// serial adder and checks results against plain-arithmetic sums.
module tb_serial_add_host;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_cin;
   logic         sa_a;
   logic         sa_b;
   logic         sa_cin;
   logic         sa_first;
   logic         sa_s;
   logic         sa_cout;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   serial_add_host #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_cin    (op_cin),
      .sa_a      (sa_a),
      .sa_b      (sa_b),
      .sa_cin    (sa_cin),
      .sa_first  (sa_first),
      .sa_s      (sa_s),
      .sa_cout   (sa_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // behavioural bit-serial adder with stored carry
   logic carry_q;
   logic c_in_bit;
   always_comb begin
      c_in_bit = sa_first ? sa_cin : carry_q;
      sa_s     = sa_a ^ sa_b ^ c_in_bit;
      sa_cout  = (sa_a & sa_b) | (sa_a & c_in_bit) | (sa_b & c_in_bit);
   end
   always @(posedge clk) begin
      if (reset) carry_q <= 1'b0;
      else       carry_q <= sa_cout;
   end

   function automatic logic [W:0] model(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic ci);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, output logic [W-1:0] s,
                        output logic co, output int lat);
      int g;
      g = 0;
      out_ready = 1'b1;
      while (!in_ready && g < 20) begin
         tick();
         g++;
      end
      op_a = a; op_b = b; op_cin = ci; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      s  = sum;
      co = carry_out;
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; op_cin = 1'b0;
      tick(); tick();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         failures++;
         $display("FAIL reset_hs got rdy/vld/busy=%b want 100",
                  {in_ready, out_valid, busy});
      end
      checks++;
      if ({sum, carry_out} !== '0) begin
         failures++;
         $display("FAIL reset_sum got %h/%b want 0/0", sum, carry_out);
      end
      checks++;
      if ({sa_a, sa_b, sa_cin, sa_first} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_sa got %b want 0000",
                  {sa_a, sa_b, sa_cin, sa_first});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_stream;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      ea = 8'h2D; eb = 8'h7A;
      out_ready = 1'b1;
      op_a = ea; op_b = eb; op_cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         checks++;
         if (sa_a !== ea[i] || sa_b !== eb[i]) begin
            failures++;
            $display("FAIL stream_bits[%0d] got a/b=%b%b want %b%b",
                     i, sa_a, sa_b, ea[i], eb[i]);
         end
         checks++;
         if (sa_first !== (i == 0) || sa_cin !== 1'b0 || out_valid) begin
            failures++;
            $display("FAIL stream_ctl[%0d] got first/cin/vld=%b%b%b",
                     i, sa_first, sa_cin, out_valid);
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b1 || sum !== 8'hA7 || carry_out !== 1'b0) begin
         failures++;
         $display("FAIL stream_result got vld=%b %h/%b want 1 a7/0",
                  out_valid, sum, carry_out);
      end
      checks++;
      if (sa_first !== 1'b0 || sa_a !== 1'b0 || sa_b !== 1'b0) begin
         failures++;
         $display("FAIL done_sa got %b%b%b want 000", sa_first, sa_a, sa_b);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'hA7) begin
         failures++;
         $display("FAIL retire got vld=%b rdy=%b sum=%h want 0 1 a7",
                  out_valid, in_ready, sum);
      end
   endtask

   task automatic test_corners;
      logic [W-1:0] ta[3];
      logic [W-1:0] tb[3];
      logic         tc[3];
      logic [W-1:0] s;
      logic         co;
      logic [W:0]   e;
      int           lat;
      ta = '{8'hFF, 8'hFF, 8'h00};
      tb = '{8'h01, 8'hFF, 8'h00};
      tc = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         do_op(ta[i], tb[i], tc[i], s, co, lat);
         e = model(ta[i], tb[i], tc[i]);
         checks++;
         if ({co, s} !== e || lat != W) begin
            failures++;
            $display("FAIL corner[%0d] got %b/%h lat=%0d want %b/%h lat=%0d",
                     i, co, s, lat, e[W], e[W-1:0], W);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] s;
      logic         co;
      logic [W:0]   e;
      int           lat;
      for (int i = 0; i < 20; i++) begin
         a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
         do_op(a, b, ci, s, co, lat);
         e = model(a, b, ci);
         checks++;
         if ({co, s} !== e || lat != W) begin
            failures++;
            $display("FAIL random[%0d] %h+%h+%b got %b/%h lat=%0d want %b/%h",
                     i, a, b, ci, co, s, lat, e[W], e[W-1:0]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] xa;
      logic [W-1:0] xb;
      logic [W:0]   e;
      logic [W:0]   ex;
      int           g;
      a = W'($urandom); b = W'($urandom);
      xa = W'($urandom); xb = W'($urandom);
      e  = model(a, b, 1'b1);
      ex = model(xa, xb, 1'b0);
      out_ready = 1'b0;
      op_a = a; op_b = b; op_cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      g = 0;
      while (!out_valid && g < 40) begin
         tick();
         g++;
      end
      for (int i = 0; i < 5; i++) begin
         op_a = xa; op_b = xb; op_cin = 1'b0; in_valid = 1'b1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {carry_out, sum} !== e) begin
            failures++;
            $display("FAIL hold[%0d] got vld=%b rdy=%b %b/%h want 1 0 %b/%h",
                     i, out_valid, in_ready, carry_out, sum, e[W], e[W-1:0]);
         end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || {carry_out, sum} !== e) begin
         failures++;
         $display("FAIL no_bypass got busy=%b rdy=%b %b/%h want 0 1 %b/%h",
                  busy, in_ready, carry_out, sum, e[W], e[W-1:0]);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL accept_after_retire got busy=%b want 1", busy);
      end
      g = 0;
      while (!out_valid && g < 40) begin
         tick();
         g++;
      end
      checks++;
      if ({carry_out, sum} !== ex || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL held_req got vld=%b %b/%h want 1 %b/%h",
                  out_valid, carry_out, sum, ex[W], ex[W-1:0]);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] s;
      logic         co;
      int           lat;
      out_ready = 1'b1;
      op_a = 8'h5A; op_b = 8'hC3; op_cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          sum !== '0 || carry_out !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got rdy=%b vld=%b busy=%b sum=%h co=%b",
                  in_ready, out_valid, busy, sum, carry_out);
      end
      for (int i = 0; i < W + 3; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_partial[%0d] got vld=%b want 0", i, out_valid);
         end
         tick();
      end
      do_op(8'h10, 8'h20, 1'b0, s, co, lat);
      checks++;
      if (s !== 8'h30 || co !== 1'b0 || lat != W) begin
         failures++;
         $display("FAIL after_reset got %h/%b lat=%0d want 30/0 lat=%0d",
                  s, co, lat, W);
      end
   endtask

   task automatic test_back_to_back;
      logic [W:0]   expq[$];
      logic [W:0]   e;
      logic [W-1:0] na;
      logic [W-1:0] nb;
      logic         nc;
      logic         acc;
      int           sent;
      int           got;
      int           last_cyc;
      sent = 0; got = 0; last_cyc = -1;
      out_ready = 1'b1;
      na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
      op_a = na; op_b = nb; op_cin = nc; in_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
         acc = in_ready & in_valid;
         tick();
         if (acc) begin
            expq.push_back(model(na, nb, nc));
            sent++;
            if (sent < 3) begin
               na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
               op_a = na; op_b = nb; op_cin = nc;
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            e = (expq.size() > 0) ? expq.pop_front() : '0;
            checks++;
            if ({carry_out, sum} !== e) begin
               failures++;
               $display("FAIL b2b_val[%0d] got %b/%h want %b/%h",
                        got, carry_out, sum, e[W], e[W-1:0]);
            end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc != W + 2) begin
                  failures++;
                  $display("FAIL b2b_gap[%0d] got %0d want %0d",
                           got, cyc - last_cyc, W + 2);
               end
            end
            last_cyc = cyc;
            got++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got != 3) begin
         failures++;
         $display("FAIL b2b_count got %0d want 3", got);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_corners();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
